// File: rtl/riscv_pkg.sv
// Shared definitions for the out-of-order core: internal opcode encoding,
// default RS/RoB widths and the "no dependency" tag helper.
package riscv_pkg;

    localparam int unsigned RS_WIDTH_DEF  = 2;
    localparam int unsigned ROB_WIDTH_DEF = 3;

    // Internal opcode encoding shared by dispatcher, RS, LSB and ALU (1..37).
    typedef enum logic [6:0] {
        OP_INVALID = 7'd0,
        LUI = 7'd1, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, ORR, ANDR
    } opcode_e;

    // Tag value meaning "operand value present, nothing to wait for".
    function automatic int unsigned non_dep(input int unsigned rob_width);
        return 32'd1 << rob_width;
    endfunction

endpackage

// File: rtl/rs_select.sv
// Combinational picker: grants the ready slot with the largest age,
// ties resolved toward the lowest index. All-zero ages give plain
// lowest-index priority. Shared with the load/store buffer.
module rs_select #(
    parameter int unsigned SEL_WIDTH = 2,
    parameter int unsigned AGE_WIDTH = 2
) (
    input  logic [(1<<SEL_WIDTH)-1:0]                ready_in,
    input  logic [(1<<SEL_WIDTH)-1:0][AGE_WIDTH-1:0] age_in,
    output logic                                     grant_valid,
    output logic [SEL_WIDTH-1:0]                     grant_index
);

    localparam int unsigned N = 1 << SEL_WIDTH;

    logic [AGE_WIDTH-1:0] best_age;

    // Scan upward; a later slot only wins with a strictly larger age.
    always_comb begin
        grant_valid = 1'b0;
        grant_index = '0;
        best_age    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ready_in[i] && (!grant_valid || age_in[i] > best_age)) begin
                grant_valid = 1'b1;
                grant_index = SEL_WIDTH'(i);
                best_age    = age_in[i];
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers ALU-class ops from the dispatcher,
// wakes operands from the ALU and load CDB ports, and issues one ready
// entry per cycle to the ALU through registered outputs.
// Optional: define RS_OLDEST_FIRST_EN for age-based (oldest-first) select.
module reservation_station
    import riscv_pkg::*;
#(
    parameter int unsigned RS_WIDTH  = RS_WIDTH_DEF,
    parameter int unsigned RoB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 newEntry_en,
    input  logic [RoB_WIDTH-1:0] newEntry_robEntry,
    input  logic [6:0]           newEntry_opcode,
    input  logic [31:0]          newEntry_Vj,
    input  logic [31:0]          newEntry_Vk,
    input  logic [RoB_WIDTH:0]   newEntry_Qj,
    input  logic [RoB_WIDTH:0]   newEntry_Qk,
    input  logic [31:0]          newEntry_imm,
    input  logic [31:0]          newEntry_pc,
    output logic                 isFull,
    input  logic                 cdb_alu_en,
    input  logic [RoB_WIDTH-1:0] cdb_alu_robEntry,
    input  logic [31:0]          cdb_alu_value,
    input  logic                 cdb_lsb_en,
    input  logic [RoB_WIDTH-1:0] cdb_lsb_robEntry,
    input  logic [31:0]          cdb_lsb_value,
    output logic                 ALU_en,
    output logic [RoB_WIDTH-1:0] ALU_robEntry,
    output logic [6:0]           ALU_opcode,
    output logic [31:0]          ALU_Vj,
    output logic [31:0]          ALU_Vk,
    output logic [31:0]          ALU_imm,
    output logic [31:0]          ALU_pc
);

    localparam int unsigned N     = 1 << RS_WIDTH;
    localparam int unsigned TAG_W = RoB_WIDTH + 1;
    localparam logic [RoB_WIDTH:0] NON_DEP = TAG_W'(non_dep(RoB_WIDTH));

    logic [N-1:0]                busy_q, busy_d;
    logic [N-1:0][6:0]           op_q, op_d;
    logic [N-1:0][31:0]          vj_q, vj_d, vk_q, vk_d, imm_q, imm_d, pc_q, pc_d;
    logic [N-1:0][RoB_WIDTH:0]   qj_q, qj_d, qk_q, qk_d;
    logic [N-1:0][RoB_WIDTH-1:0] rob_q, rob_d;
`ifdef RS_OLDEST_FIRST_EN
    logic [N-1:0][RS_WIDTH-1:0]  age_q, age_d;
`endif
    logic [N-1:0][RS_WIDTH-1:0]  sel_age;

    logic                 alu_en_q, alu_en_d;
    logic [RoB_WIDTH-1:0] alu_rob_q, alu_rob_d;
    logic [6:0]           alu_op_q, alu_op_d;
    logic [31:0]          alu_vj_q, alu_vj_d, alu_vk_q, alu_vk_d;
    logic [31:0]          alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;

    logic [RS_WIDTH:0]    free_cnt;
    logic [RS_WIDTH-1:0]  free_idx;
    logic                 have_free;
    logic [N-1:0]         ready_vec;
    logic                 grant_valid;
    logic [RS_WIDTH-1:0]  grant_index;

    // Tag bit RoB_WIDTH set means no dependency; ALU port wins a tag tie.
    function automatic logic [RoB_WIDTH+32:0] wake(input logic [RoB_WIDTH:0] q_in,
                                                   input logic [31:0]        v_in);
        logic [RoB_WIDTH+32:0] r;
        r = {q_in, v_in};
        if (cdb_alu_en && q_in == {1'b0, cdb_alu_robEntry})
            r = {NON_DEP, cdb_alu_value};
        else if (cdb_lsb_en && q_in == {1'b0, cdb_lsb_robEntry})
            r = {NON_DEP, cdb_lsb_value};
        return r;
    endfunction

    // Free-slot count, lowest free slot, back-pressure and ready vector.
    always_comb begin
        free_cnt  = '0;
        free_idx  = '0;
        have_free = 1'b0;
        ready_vec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!busy_q[i]) begin
                free_cnt = free_cnt + (RS_WIDTH+1)'(1);
                if (!have_free) begin
                    have_free = 1'b1;
                    free_idx  = RS_WIDTH'(i);
                end
            end
            ready_vec[i] = busy_q[i] && qj_q[i][RoB_WIDTH] && qk_q[i][RoB_WIDTH];
        end
        isFull = (free_cnt == '0) || (free_cnt == (RS_WIDTH+1)'(1) && newEntry_en);
    end

`ifdef RS_OLDEST_FIRST_EN
    assign sel_age = age_q;
`else
    assign sel_age = '0;
`endif

    rs_select #(
        .SEL_WIDTH (RS_WIDTH),
        .AGE_WIDTH (RS_WIDTH)
    ) u_select (
        .ready_in    (ready_vec),
        .age_in      (sel_age),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    // Next state: flush beats everything; else wakeup, issue, then write.
    // Select and free-slot choice both use pre-edge busy, so the issuing
    // slot is never reused in the same cycle.
    always_comb begin
        busy_d = busy_q;  op_d = op_q;  rob_d = rob_q;
        vj_d = vj_q;  vk_d = vk_q;  qj_d = qj_q;  qk_d = qk_q;
        imm_d = imm_q;  pc_d = pc_q;
`ifdef RS_OLDEST_FIRST_EN
        age_d = age_q;
`endif
        alu_en_d = alu_en_q;  alu_rob_d = alu_rob_q;  alu_op_d = alu_op_q;
        alu_vj_d = alu_vj_q;  alu_vk_d = alu_vk_q;
        alu_imm_d = alu_imm_q;  alu_pc_d = alu_pc_q;

        if (rdy_in) begin
            if (flush_in) begin
                busy_d   = '0;
                alu_en_d = 1'b0;
            end else begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (busy_q[i]) begin
                        {qj_d[i], vj_d[i]} = wake(qj_q[i], vj_q[i]);
                        {qk_d[i], vk_d[i]} = wake(qk_q[i], vk_q[i]);
                    end
                end

                alu_en_d = grant_valid;
                if (grant_valid) begin
                    busy_d[grant_index] = 1'b0;
                    alu_rob_d = rob_q[grant_index];
                    alu_op_d  = op_q[grant_index];
                    alu_vj_d  = vj_q[grant_index];
                    alu_vk_d  = vk_q[grant_index];
                    alu_imm_d = imm_q[grant_index];
                    alu_pc_d  = pc_q[grant_index];
                end

                if (newEntry_en && have_free) begin
`ifdef RS_OLDEST_FIRST_EN
                    // Saturate rather than wrap so a long-waiting entry
                    // never looks younger than one written after it.
                    for (int unsigned i = 0; i < N; i++) begin
                        if (busy_q[i] && age_q[i] != '1)
                            age_d[i] = age_q[i] + RS_WIDTH'(1);
                    end
                    age_d[free_idx] = '0;
`endif
                    busy_d[free_idx] = 1'b1;
                    op_d[free_idx]   = newEntry_opcode;
                    rob_d[free_idx]  = newEntry_robEntry;
                    imm_d[free_idx]  = newEntry_imm;
                    pc_d[free_idx]   = newEntry_pc;
                    {qj_d[free_idx], vj_d[free_idx]} = wake(newEntry_Qj, newEntry_Vj);
                    {qk_d[free_idx], vk_d[free_idx]} = wake(newEntry_Qk, newEntry_Vk);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;  op_q <= '0;  rob_q <= '0;
            vj_q <= '0;  vk_q <= '0;  qj_q <= '0;  qk_q <= '0;
            imm_q <= '0;  pc_q <= '0;
`ifdef RS_OLDEST_FIRST_EN
            age_q <= '0;
`endif
            alu_en_q <= 1'b0;  alu_rob_q <= '0;  alu_op_q <= '0;
            alu_vj_q <= '0;  alu_vk_q <= '0;  alu_imm_q <= '0;  alu_pc_q <= '0;
        end else begin
            busy_q <= busy_d;  op_q <= op_d;  rob_q <= rob_d;
            vj_q <= vj_d;  vk_q <= vk_d;  qj_q <= qj_d;  qk_q <= qk_d;
            imm_q <= imm_d;  pc_q <= pc_d;
`ifdef RS_OLDEST_FIRST_EN
            age_q <= age_d;
`endif
            alu_en_q <= alu_en_d;  alu_rob_q <= alu_rob_d;  alu_op_q <= alu_op_d;
            alu_vj_q <= alu_vj_d;  alu_vk_q <= alu_vk_d;
            alu_imm_q <= alu_imm_d;  alu_pc_q <= alu_pc_d;
        end
    end

    assign ALU_en       = alu_en_q;
    assign ALU_robEntry = alu_rob_q;
    assign ALU_opcode   = alu_op_q;
    assign ALU_Vj       = alu_vj_q;
    assign ALU_Vk       = alu_vk_q;
    assign ALU_imm      = alu_imm_q;
    assign ALU_pc       = alu_pc_q;

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the dispatcher→RS issue interface.
- Buffers ALU-class ops: jalr, branches, I-type and R-type arithmetic.
- Wakes up pending operands by snooping two CDB ports: ALU result and LSB load result.
- Each cycle, issues at most one operand-ready entry to the ALU with a registered handshake.

Parameters:
RS_WIDTH, 2, log2 of entry count (4 entries)
RoB_WIDTH, 3, RoB index width; tags are RoB_WIDTH+1 bits
NON_DEP, 1<<RoB_WIDTH, tag value meaning "operand valid, no dependency"

Ports:
clk_in  in  1  clock, all state on rising edge
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; 0 freezes all state and outputs
flush_in  in  1  RoB misprediction flush
newEntry_en  in  1  dispatcher writes one entry this cycle
newEntry_robEntry  in  RoB_WIDTH  destination RoB index
newEntry_opcode  in  7  internal opcode (shared encoding, 1..37)
newEntry_Vj / newEntry_Vk  in  32 each  operand values
newEntry_Qj / newEntry_Qk  in  RoB_WIDTH+1 each  operand tags
newEntry_imm / newEntry_pc  in  32 each  immediate, instruction pc
isFull  out  1  combinational back-pressure to dispatcher
cdb_alu_en, cdb_alu_robEntry, cdb_alu_value  in  1/RoB_WIDTH/32  ALU broadcast
cdb_lsb_en, cdb_lsb_robEntry, cdb_lsb_value  in  1/RoB_WIDTH/32  load broadcast
ALU_en  out  1  registered issue strobe
ALU_robEntry, ALU_opcode, ALU_Vj, ALU_Vk, ALU_imm, ALU_pc  out  RoB_WIDTH/7/32/32/32/32  issued op

Behaviour:
- Reset (async, rst_n_in=0): all busy bits=0, ALU_en=0, all ALU_* data outputs=0. isFull=0 immediately.
- Entry state: busy, opcode, Vj, Vk, Qj, Qk, imm, pc, robEntry. An operand is ready when its tag == NON_DEP.
- Write:
  - When newEntry_en=1 and no flush, store into the lowest-index free entry at the clock edge.
  - The dispatcher never writes when full: isFull covers its one-cycle register lag.
- isFull = (free==0) || (free==1 && newEntry_en). Entries freed by the same-cycle issue are not credited (conservative).
- Wakeup:
  - For every busy entry, and for the entry being written this cycle: if cdb_X_en && Qj=={0,cdb_X_robEntry}, set Vj=value and Qj=NON_DEP. Same rule for Qk.
  - Both CDB ports may hit the same entry on different operands in one cycle.
  - If both ports carry the same tag, the ALU port wins (cannot occur legally; deterministic anyway).
- Select: busy && Qj==NON_DEP && Qk==NON_DEP, judged on pre-edge state; the lowest index wins.
  - Next edge: ALU_en=1, ALU_* loaded from the winner, winner busy cleared. Otherwise ALU_en=0.
  - Latency: an entry written at edge t with both operands ready issues at edge t+1 (ALU_en high during cycle t+1..t+2).
  - An operand woken at edge t is selectable for edge t+1. There is no same-cycle CDB bypass to issue.
- Flush (flush_in=1): all busy cleared, ALU_en=0 at next edge. A newEntry_en in the same cycle is dropped. Flush has priority over write, wakeup and issue.
- rdy_in=0: nothing changes. ALU_en holds its value (the ALU also ignores it while paused).
- Unused tag rule: tag bit RoB_WIDTH set means NON_DEP regardless of the low bits.

Optional Feature:
RS_OLDEST_FIRST_EN
- Defined: each entry holds an age counter of RS_WIDTH bits.
  - Incremented on every successful write elsewhere while the entry is busy; reset to 0 on write.
  - Select picks the ready entry with the largest age; ties go to the lowest index.
- Undefined: pure lowest-index priority, no age storage.

Decomposition:
- Shared package riscv_pkg: 7-bit opcode constants (lui..andr), NON_DEP function of RoB_WIDTH, RS/RoB width defaults.
- One sub-module, rs_select: combinational priority/age picker. Inputs: ready vector (and ages). Outputs: grant_valid, grant_index. Reused by the LSB.

Test Plan:
- Reset: assert rst_n_in=0 mid-cycle with 3 busy entries → ALU_en=0 and isFull=0 immediately, with no clock edge; no issue after release.
- Ready write: write add rob=2, Qj=Qk=8, Vj=5, Vk=7 → ALU_en=1 one cycle later, ALU_robEntry=2, Vj=5, Vk=7; entry freed.
- Wakeup, both ports: write sub rob=3, Qj=1, Qk=4. In the same cycle cdb_alu rob=1 value=0x10 and cdb_lsb rob=4 value=0x3 → both operands captured; issue next cycle with Vj=0x10, Vk=0x3.
- Full, back-to-back: 4 dependent writes on tag 0 with free=1 and newEntry_en=1 → isFull=1. Broadcast rob=0 → issues in index order 0,1,2,3 over 4 cycles; isFull drops after the first issue.
- Flush: flush_in=1 together with newEntry_en=1 and one ready entry → ALU_en=0 next cycle, all entries empty, new entry discarded.
- With RS_OLDEST_FIRST_EN: write A to idx0, free idx0 by issue, fill idx0 with a newer op while older B sits in idx1; make both ready → B issues first.
